// File: rtl/bram_unaligned.sv
// Byte-addressed 1R/1W RAM with unaligned 1/2/4-byte access, built from four byte-lane banks.
// Optional macro BRAM_UNALIGNED_BYPASS_EN selects write-first behaviour for same-cycle overlapping bytes.
module bram_unaligned #(
  parameter int DEPTH_BYTES = 2048,
  parameter     INIT_FILE   = "",
  localparam int AW = $clog2(DEPTH_BYTES)
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  input  logic [1:0]    rsize,
  input  logic          rsigned,
  input  logic          wren,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wsize,
  input  logic [31:0]   wdata,
  output logic [31:0]   out,
  output logic          rvalid
);

  localparam int ROWS = DEPTH_BYTES / 4;
  localparam int RW   = AW - 2;

  // Size code 3 is treated as a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] ext_load(input logic [31:0] raw, input logic [1:0] size,
                                           input logic sgn);
    case (size)
      2'd0:    ext_load = {{24{sgn & raw[7]}}, raw[7:0]};
      2'd1:    ext_load = {{16{sgn & raw[15]}}, raw[15:0]};
      default: ext_load = raw;
    endcase
  endfunction

  logic [1:0]    roff_p0  [4];
  logic [1:0]    woff_p0  [4];
  logic [RW-1:0] rrow_p0  [4];
  logic [RW-1:0] wrow_p0  [4];
  logic [3:0]    wen_p0;
  logic [7:0]    wbyte_p0 [4];
  logic [7:0]    rbyte_p0 [4];
  logic [7:0]    lane_p0  [4];
  logic [31:0]   raw_p0;
  logic [31:0]   load_p0;
  logic [31:0]   out_p1;
  logic          vld_p1;

  // Stage p0: per-lane row decode, write lane enables, read merge and extension.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      roff_p0[k]  = 2'(k) - raddr[1:0];
      woff_p0[k]  = 2'(k) - waddr[1:0];
      rrow_p0[k]  = RW'((raddr + AW'(roff_p0[k])) >> 2);
      wrow_p0[k]  = RW'((waddr + AW'(woff_p0[k])) >> 2);
      wen_p0[k]   = wren && ({1'b0, woff_p0[k]} < size_bytes(wsize));
      wbyte_p0[k] = wdata[8*woff_p0[k] +: 8];
`ifdef BRAM_UNALIGNED_BYPASS_EN
      lane_p0[k]  = (wen_p0[k] && (wrow_p0[k] == rrow_p0[k])) ? wbyte_p0[k] : rbyte_p0[k];
`else
      lane_p0[k]  = rbyte_p0[k];
`endif
    end
    raw_p0 = '0;
    for (int i = 0; i < 4; i++) begin
      raw_p0[8*i +: 8] = lane_p0[2'(raddr[1:0] + 2'(i))];
    end
    load_p0 = ext_load(raw_p0, rsize, rsigned);
  end

  genvar k;
  for (k = 0; k < 4; k++) begin : g_lane
    logic [7:0] mem [ROWS];

    always_ff @(posedge clock) begin
      if (rst_n && wen_p0[k]) mem[wrow_p0[k]] <= wbyte_p0[k];
    end

    assign rbyte_p0[k] = mem[rrow_p0[k]];
  end

  // Stage p1: registered read data and valid.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      out_p1 <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= ren;
      if (ren) out_p1 <= load_p0;
    end
  end

  assign out    = out_p1;
  assign rvalid = vld_p1;

endmodule

// File: tb/tb_bram_unaligned.sv
// Directed testbench for bram_unaligned (DEPTH_BYTES=2048) with hand-computed expectations
// and a byte-level reference model for the address sweep.
module tb_bram_unaligned;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        ren;
  logic [10:0] raddr;
  logic [1:0]  rsize;
  logic        rsigned;
  logic        wren;
  logic [10:0] waddr;
  logic [1:0]  wsize;
  logic [31:0] wdata;
  logic [31:0] out;
  logic        rvalid;

  logic [7:0]  model [2048];
  int          n_vec = 0;
  int          n_bad = 0;

  bram_unaligned #(.DEPTH_BYTES(2048)) dut (
    .clock(clock), .rst_n(rst_n),
    .ren(ren), .raddr(raddr), .rsize(rsize), .rsigned(rsigned),
    .wren(wren), .waddr(waddr), .wsize(wsize), .wdata(wdata),
    .out(out), .rvalid(rvalid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input logic [10:0] a, input logic [1:0] s,
                                             input logic sg);
    int          nb;
    logic [31:0] v;
    nb = nbytes(s);
    v  = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = model[11'(a + 11'(i))];
    if (sg) for (int b = 8*nb; b < 32; b++) v[b] = v[8*nb-1];
    return v;
  endfunction

  task automatic step(input logic r, input logic [10:0] ra, input logic [1:0] rs, input logic rsg,
                      input logic w, input logic [10:0] wa, input logic [1:0] ws,
                      input logic [31:0] wd);
    ren = r; raddr = ra; rsize = rs; rsigned = rsg;
    wren = w; waddr = wa; wsize = ws; wdata = wd;
    @(posedge clock);
    if (w && rst_n) for (int i = 0; i < nbytes(ws); i++) model[11'(wa + 11'(i))] = wd[8*i +: 8];
    #1;
    ren = 1'b0;
    wren = 1'b0;
  endtask

  task automatic wr(input logic [10:0] a, input logic [1:0] s, input logic [31:0] d);
    step(1'b0, 11'd0, 2'd0, 1'b0, 1'b1, a, s, d);
  endtask

  task automatic rd(input logic [10:0] a, input logic [1:0] s, input logic sg);
    step(1'b1, a, s, sg, 1'b0, 11'd0, 2'd0, 32'd0);
  endtask

  task automatic idle();
    step(1'b0, 11'd0, 2'd0, 1'b0, 1'b0, 11'd0, 2'd0, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; ren = 1'b0; raddr = '0; rsize = '0; rsigned = 1'b0;
    wren = 1'b0; waddr = '0; wsize = '0; wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_out", out, 32'h0);
    check("reset_vld", {31'b0, rvalid}, 32'h0);
    rst_n = 1'b1;

    for (int a = 0; a < 2048; a += 4) wr(11'(a), 2'd2, 32'h0);

    // Aligned-free word write and read back, with latency and hold checks.
    wr(11'h011, 2'd2, 32'h12345678);
    rd(11'h011, 2'd2, 1'b0);
    check("t1_word", out, 32'h12345678);
    check("t1_vld", {31'b0, rvalid}, 32'h1);
    idle();
    check("t1_hold", out, 32'h12345678);
    check("t1_vld_low", {31'b0, rvalid}, 32'h0);

    rd(11'h010, 2'd2, 1'b0);
    check("t2_word10", out, 32'h34567800);
    rd(11'h013, 2'd1, 1'b0);
    check("t2_half13", out, 32'h00001234);
    rd(11'h014, 2'd1, 1'b0);
    check("t2_half14", out, 32'h00000012);

    // End-of-memory wrap.
    wr(11'h7FE, 2'd2, 32'hA1B2C3D4);
    rd(11'h000, 2'd2, 1'b0);
    check("t3_word0", out, 32'h0000A1B2);
    rd(11'h7FE, 2'd1, 1'b0);
    check("t3_half7fe", out, 32'h0000C3D4);
    rd(11'h7FE, 2'd2, 1'b0);
    check("t3_word7fe", out, 32'hA1B2C3D4);

    // Sign extension.
    wr(11'h020, 2'd0, 32'hFFFFFF80);
    rd(11'h020, 2'd0, 1'b0);
    check("t4_byte_u", out, 32'h00000080);
    rd(11'h020, 2'd0, 1'b1);
    check("t4_byte_s", out, 32'hFFFFFF80);
    rd(11'h01F, 2'd1, 1'b1);
    check("t4_half_s", out, 32'hFFFF8000);
    wr(11'h031, 2'd1, 32'hFFFFBEEF);
    rd(11'h030, 2'd2, 1'b0);
    check("t4_half_wr", out, 32'h00BEEF00);
    wr(11'h051, 2'd3, 32'hCAFEF00D);
    rd(11'h051, 2'd3, 1'b0);
    check("t4_size3", out, 32'hCAFEF00D);

    // Strided words then a full word-read sweep against the byte model.
    for (int i = 0; i < 16; i++) wr(11'(i*17), 2'd2, 32'h12345678);
    for (int a = 0; a < 256; a++) begin
      rd(11'(a), 2'd2, 1'b0);
      check($sformatf("t5_sweep_%02h", a), out, model_read(11'(a), 2'd2, 1'b0));
    end

    // Same-cycle read/write collisions.
    wr(11'h040, 2'd2, 32'h11111111);
    step(1'b1, 11'h040, 2'd2, 1'b0, 1'b1, 11'h040, 2'd2, 32'hDEADBEEF);
`ifdef BRAM_UNALIGNED_BYPASS_EN
    check("t6_overlap", out, 32'hDEADBEEF);
`else
    check("t6_overlap", out, 32'h11111111);
`endif
    step(1'b1, 11'h040, 2'd2, 1'b0, 1'b1, 11'h043, 2'd0, 32'h00000055);
`ifdef BRAM_UNALIGNED_BYPASS_EN
    check("t6_partial", out, 32'h55ADBEEF);
`else
    check("t6_partial", out, 32'hDEADBEEF);
`endif
    step(1'b1, 11'h040, 2'd2, 1'b0, 1'b1, 11'h080, 2'd2, 32'h77777777);
    check("t6_disjoint", out, 32'h55ADBEEF);
    rd(11'h080, 2'd2, 1'b0);
    check("t6_disj_wr", out, 32'h77777777);

    // Reset during an active read and write.
    rst_n = 1'b0;
    step(1'b1, 11'h011, 2'd2, 1'b0, 1'b1, 11'h060, 2'd2, 32'h99999999);
    check("t7_rst_out", out, 32'h0);
    check("t7_rst_vld", {31'b0, rvalid}, 32'h0);
    rst_n = 1'b1;
    idle();
    check("t7_post_vld", {31'b0, rvalid}, 32'h0);
    rd(11'h060, 2'd2, 1'b0);
    check("t7_no_write", out, 32'h00000000);
    check("t7_model", out, model_read(11'h060, 2'd2, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
